// File: rtl/prio_enc_rr.sv
// prio_enc_rr: priority encoder, fixed or round-robin, one-entry output reg.
// Ports: clk_i, rst_n_i (async low), inp_i requests, ready_i accept,
//        out_o index, onehot_o one-hot of out_o, valid_o result present.
module prio_enc_rr #(
    parameter int WIDTH   = 16,
    parameter int RR_MODE = 0,
    localparam int IDXW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] inp_i,
    input  logic             ready_i,
    output logic [IDXW-1:0]  out_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic             valid_o
);

    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    logic [IDXW-1:0]  out_q, out_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic             valid_q, valid_d;

    logic             load;
    logic             accept;
    logic [IDXW-1:0]  next_ptr;
    logic [IDXW-1:0]  base;
    logic [IDXW-1:0]  sel_idx;
    logic             found;
    int               scan_j;

    always_comb begin
        load     = !valid_q || ready_i;
        accept   = valid_q && ready_i;
        // wrap explicitly so non-power-of-2 widths never reach WIDTH
        next_ptr = (out_q == LAST) ? '0 : out_q + 1'b1;

        ptr_d = ptr_q;
        if (RR_MODE != 0 && accept && |inp_i) begin
            ptr_d = next_ptr;
        end

        // a same-cycle accept+reload scans from the already-advanced pointer
        base = (RR_MODE != 0) ? ptr_d : '0;

        sel_idx = '0;
        found   = 1'b0;
        scan_j  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            scan_j = int'(base) + i;
            if (scan_j >= WIDTH) begin
                scan_j = scan_j - WIDTH;
            end
            if (!found && inp_i[IDXW'(scan_j)]) begin
                found   = 1'b1;
                sel_idx = IDXW'(scan_j);
            end
        end

        out_d    = out_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        if (load) begin
            if (found) begin
                out_d    = sel_idx;
                onehot_d = WIDTH'(1) << sel_idx;
                valid_d  = 1'b1;
            end else begin
                onehot_d = '0;
                valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q    <= '0;
            ptr_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            ptr_q    <= ptr_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign out_o    = out_q;
    assign onehot_o = onehot_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb_prio_enc_rr: fixed (16), round-robin (16) and round-robin (12)
// instances driven by directed and random stimulus against a model.
module tb_prio_enc_rr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] inp16 = '0;
    logic [11:0] inp12 = '0;

    logic [3:0]  f_out, r_out, t_out;
    logic [15:0] f_oh, r_oh;
    logic [11:0] t_oh;
    logic        f_v, r_v, t_v;

    int checks = 0;
    int errors = 0;

    int m_valid [3];
    int m_out   [3];
    int m_ptr   [3];
    int m_w     [3] = '{16, 16, 12};
    int m_rr    [3] = '{0, 1, 1};

    prio_enc_rr #(.WIDTH(16), .RR_MODE(0)) u_fix (
        .clk_i(clk), .rst_n_i(rst_n), .inp_i(inp16), .ready_i(ready),
        .out_o(f_out), .onehot_o(f_oh), .valid_o(f_v));

    prio_enc_rr #(.WIDTH(16), .RR_MODE(1)) u_rr (
        .clk_i(clk), .rst_n_i(rst_n), .inp_i(inp16), .ready_i(ready),
        .out_o(r_out), .onehot_o(r_oh), .valid_o(r_v));

    prio_enc_rr #(.WIDTH(12), .RR_MODE(1)) u_rr12 (
        .clk_i(clk), .rst_n_i(rst_n), .inp_i(inp12), .ready_i(ready),
        .out_o(t_out), .onehot_o(t_oh), .valid_o(t_v));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            m_out[k]   = 0;
            m_ptr[k]   = 0;
        end
    endtask

    // first requester found walking upward from base, wrapping modulo w
    function automatic int grant(input logic [63:0] v, input int base,
                                 input int w);
        for (int o = 0; o < w; o++) begin
            if (v[(base + o) % w]) return (base + o) % w;
        end
        return -1;
    endfunction

    task automatic mstep(input int k, input logic [63:0] v, input bit rdy);
        bit ld, acc;
        ld  = (m_valid[k] == 0) || rdy;
        acc = (m_valid[k] == 1) && rdy;
        if (m_rr[k] != 0 && acc && v != 0)
            m_ptr[k] = (m_out[k] + 1) % m_w[k];
        if (ld) begin
            if (v != 0) begin
                m_out[k]   = grant(v, (m_rr[k] != 0) ? m_ptr[k] : 0, m_w[k]);
                m_valid[k] = 1;
            end else begin
                m_valid[k] = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        inp16 = 16'hFFFF;
        inp12 = 12'hFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({f_v, r_v, t_v} !== 3'b000 || f_out !== 4'h0 ||
                f_oh !== 16'h0 || r_oh !== 16'h0 || t_oh !== 12'h0) begin
                errors++;
                $display("FAIL reset_hold: v=%b fout=%h foh=%h roh=%h toh=%h want all 0",
                         {f_v, r_v, t_v}, f_out, f_oh, r_oh, t_oh);
            end
        end
        inp16 = '0;
        inp12 = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({f_v, r_v, t_v} !== 3'b000 || f_oh !== 16'h0 ||
                r_oh !== 16'h0 || t_oh !== 12'h0) begin
                errors++;
                $display("FAIL idle_zero: v=%b foh=%h roh=%h toh=%h want 0",
                         {f_v, r_v, t_v}, f_oh, r_oh, t_oh);
            end
        end
    endtask

    task automatic test_fixed();
        ready = 1'b1;
        inp16 = 16'h0110;
        tick();
        checks++;
        if (f_out !== 4'h4 || f_oh !== 16'h0010 || f_v !== 1'b1) begin
            errors++;
            $display("FAIL fixed_0110: out=%h oh=%h v=%b want 4 0010 1",
                     f_out, f_oh, f_v);
        end
        inp16 = 16'h8000;
        tick();
        checks++;
        if (f_out !== 4'hF || f_oh !== 16'h8000 || f_v !== 1'b1) begin
            errors++;
            $display("FAIL fixed_8000: out=%h oh=%h v=%b want F 8000 1",
                     f_out, f_oh, f_v);
        end
    endtask

    task automatic test_hold();
        ready = 1'b1;
        inp16 = 16'h0110;
        tick();
        ready = 1'b0;
        inp16 = 16'h0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (f_out !== 4'h4 || f_oh !== 16'h0010 || f_v !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: out=%h oh=%h v=%b want 4 0010 1",
                         c, f_out, f_oh, f_v);
            end
        end
        ready = 1'b1;
        tick();
        checks++;
        if (f_out !== 4'h0 || f_oh !== 16'h0001 || f_v !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out=%h oh=%h want 0 0001", f_out, f_oh);
        end
    endtask

    task automatic test_rr_wrap();
        logic [3:0] exp16 [5] = '{4'h0, 4'h4, 4'hF, 4'h0, 4'h4};
        apply_reset();
        ready = 1'b1;
        inp16 = 16'h8011;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (r_out !== exp16[c] || r_v !== 1'b1 ||
                r_oh !== (16'h1 << exp16[c])) begin
                errors++;
                $display("FAIL rr_wrap_%0d: out=%h oh=%h v=%b want %h",
                         c, r_out, r_oh, r_v, exp16[c]);
            end
        end
    endtask

    task automatic test_rr_width12();
        logic [3:0] exp12 [4] = '{4'h0, 4'hB, 4'h0, 4'hB};
        apply_reset();
        ready = 1'b1;
        inp12 = 12'h801;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (t_out !== exp12[c] || t_v !== 1'b1 ||
                t_oh !== (12'h1 << exp12[c])) begin
                errors++;
                $display("FAIL rr12_%0d: out=%h oh=%h v=%b want %h",
                         c, t_out, t_oh, t_v, exp12[c]);
            end
        end
        inp12 = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ready = 1'b1;
        inp16 = 16'h8011;
        tick();
        tick();
        ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_v !== 1'b0 || r_out !== 4'h0 || r_oh !== 16'h0 ||
            f_v !== 1'b0 || f_oh !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: rv=%b rout=%h roh=%h fv=%b want 0",
                     r_v, r_out, r_oh, f_v);
        end
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        checks++;
        if (r_out !== 4'h0 || r_v !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart0: out=%h v=%b want 0 1", r_out, r_v);
        end
        tick();
        checks++;
        if (r_out !== 4'h4 || r_v !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart1: out=%h v=%b want 4 1", r_out, r_v);
        end
    endtask

    task automatic test_random();
        logic [63:0] eoh, aoh;
        int          aout, av;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0: begin inp16 = '0; inp12 = '0; end
                1: begin
                    inp16 = 16'h1 << $urandom_range(0, 15);
                    inp12 = 12'h1 << $urandom_range(0, 11);
                end
                default: begin
                    inp16 = 16'($urandom);
                    inp12 = 12'($urandom);
                end
            endcase
            mstep(0, {48'h0, inp16}, ready);
            mstep(1, {48'h0, inp16}, ready);
            mstep(2, {52'h0, inp12}, ready);
            tick();
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: begin aout = f_out; av = f_v; aoh = {48'h0, f_oh}; end
                    1: begin aout = r_out; av = r_v; aoh = {48'h0, r_oh}; end
                    default: begin aout = t_out; av = t_v; aoh = {52'h0, t_oh}; end
                endcase
                eoh = (m_valid[k] != 0) ? (64'h1 << m_out[k]) : 64'h0;
                checks++;
                if (aout !== m_out[k] || av !== m_valid[k] || aoh !== eoh) begin
                    errors++;
                    $display("FAIL rand_c%0d_dut%0d: out=%0d v=%0d oh=%h want %0d %0d %h",
                             c, k, aout, av, aoh, m_out[k], m_valid[k], eoh);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_hold();
        test_rr_wrap();
        test_rr_width12();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 Parameter WIDTH, default 16, number of request bits (legal range 2..64, need not be a power of 2).
REQ-002 Parameter RR_MODE, default 0, selects arbitration: 0 = fixed priority, 1 = round-robin.
REQ-003 Derived localparam IDXW = $clog2(WIDTH), the index width (4 at default).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 inp_i  input  WIDTH  request vector; bit k set means index k requests.
REQ-007 ready_i  input  1  downstream accepts the current result this cycle.
REQ-008 out_o  output  IDXW  registered binary index of the selected request.
REQ-009 onehot_o  output  WIDTH  registered one-hot form of out_o; all zero when valid_o=0.
REQ-010 valid_o  output  1  registered; out_o/onehot_o hold a result.

Function
REQ-011 Output stage is a one-entry register; "load" condition = (valid_o==0) or (valid_o==1 and ready_i==1).
REQ-012 On a load edge with inp_i!=0: out_o <= selected index, onehot_o <= 1<<index, valid_o <= 1; latency exactly 1 cycle from inp_i to valid_o.
REQ-013 On a load edge with inp_i==0: valid_o <= 0, onehot_o <= 0, out_o unchanged.
REQ-014 Hold: while valid_o==1 and ready_i==0, out_o, onehot_o, valid_o remain stable regardless of inp_i.
REQ-015 Fixed mode: selected index = lowest set bit of inp_i (bit 0 highest priority).
REQ-016 Round-robin mode: internal pointer ptr (IDXW bits, range 0..WIDTH-1); selected index = first set bit scanning ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
REQ-017 ptr updates only on an accepted handshake (valid_o & ready_i): ptr <= out_o+1, wrapping WIDTH-1 -> 0 (also for non-power-of-2 WIDTH).
REQ-018 ptr unchanged when the result is held, when inp_i==0, and always in fixed mode (stays 0).
REQ-019 Accept and reload in the same cycle: selection for the new load uses the already-updated pointer (out_o+1), so the same index is not regranted back-to-back while another bit requests.
REQ-020 inp_i bits at positions >= WIDTH do not exist; a single requester is selected every accepted cycle in both modes.
REQ-021 No combinational path from inp_i or ready_i to any output.

Reset
REQ-022 rst_n_i low forces immediately, without a clock edge: valid_o=0, out_o=0, onehot_o=0, ptr=0.
REQ-023 Reset asserted mid-hold discards the held result; first load after release follows REQ-012 with ptr=0.
REQ-024 Outputs stay at reset values while rst_n_i is low, whatever the other inputs.

Verification
REQ-025 Reset, inp_i=16'h0000, ready_i=1 -> valid_o=0, onehot_o=0 on every edge.
REQ-026 Fixed mode, inp_i=16'h0110, ready_i=1 -> one edge later out_o=4'h4, onehot_o=16'h0010, valid_o=1; inp_i=16'h8000 -> out_o=4'hF.
REQ-027 Hold: result out_o=4'h4 valid, ready_i=0, inp_i changed to 16'h0001 for 3 cycles -> out_o stays 4'h4; ready_i=1 -> next edge out_o=4'h0.
REQ-028 RR mode, inp_i=16'h8011 constant, ready_i=1 -> successive accepted out_o = 0, 4, F, 0, 4 (wrap verified).
REQ-029 RR mode, WIDTH=12, inp_i=12'h801 constant, ready_i=1 -> out_o = 0, B, 0, B; ptr never exceeds 11.
REQ-030 rst_n_i pulsed low between edges while valid_o=1 -> valid_o, out_o, onehot_o drop to 0 before next edge; RR grant sequence restarts from index 0.
